// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request/response plus memory-side bus of the load/store unit.
interface load_store_unit_if;
  logic        valid;
  logic        ready;
  logic        write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  modport slave (
    input  valid, write, funct3, addr, wdata, mem_ack, mem_rdata,
    output ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, done, rdata, fault
  );
  modport master (
    output valid, write, funct3, addr, wdata, mem_ack, mem_rdata,
    input  ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, done, rdata, fault
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer (IDLE/REQ/DONE) with lane steering, extension and ack timeout.
// Defining LSU_MISALIGN_TRAP_EN faults misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [2:0] f3;
  logic [1:0] lo;
  logic wr, bad;
  logic [3:0] be;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic [31:0] wrep, ld;
  always_comb begin
    bad = bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11 || (bus.write && bus.funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || (bus.funct3[1:0] == 2'b01 && bus.addr[0]) || (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
`endif
    be = bus.funct3[1:0] == 2'b00 ? 4'b0001 << bus.addr[1:0] :
         bus.funct3[1:0] == 2'b01 ? 4'b0011 << {bus.addr[1], 1'b0} : 4'b1111;
    wrep = bus.funct3[1:0] == 2'b00 ? {4{bus.wdata[7:0]}} :
           bus.funct3[1:0] == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
    bsel = 8'(bus.mem_rdata >> {lo, 3'b000});
    hsel = 16'(bus.mem_rdata >> {lo[1], 4'b0000});
    ld = f3[1:0] == 2'b00 ? {{24{bsel[7] & ~f3[2]}}, bsel} :
         f3[1:0] == 2'b01 ? {{16{hsel[15] & ~f3[2]}}, hsel} : bus.mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      lo <= '0;
      wr <= 1'b0;
      bus.ready <= 1'b1;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be <= '0;
      bus.done <= 1'b0;
      bus.rdata <= '0;
      bus.fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.valid) begin
          wr <= bus.write;
          f3 <= bus.funct3;
          lo <= bus.addr[1:0];
          cnt <= '0;
          bus.ready <= 1'b0;
          if (bad) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.fault <= 1'b1;
          end else begin
            state <= REQ;
            bus.mem_req <= 1'b1;
            bus.mem_we <= bus.write;
            bus.mem_addr <= {bus.addr[31:2], 2'b00};
            bus.mem_be <= be;
            bus.mem_wdata <= bus.write ? wrep : '0;
          end
        end
        REQ: if (bus.mem_ack || cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state <= DONE;
          bus.mem_req <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.mem_addr <= '0;
          bus.mem_wdata <= '0;
          bus.mem_be <= '0;
          bus.done <= 1'b1;
          bus.fault <= !bus.mem_ack;
          bus.rdata <= (bus.mem_ack && !wr) ? ld : '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DONE: begin
          state <= IDLE;
          bus.ready <= 1'b1;
          bus.done <= 1'b0;
          bus.fault <= 1'b0;
          bus.rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses checked against a byte-arithmetic reference model.
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  load_store_unit_if bus();
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic noise();
    bus.valid = 1'($urandom);
    bus.write = 1'($urandom);
    bus.funct3 = 3'($urandom);
    bus.addr = $urandom;
    bus.wdata = $urandom;
    bus.mem_rdata = $urandom;
  endtask
  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int dly);
    int size, off;
    bit bad, flt;
    logic [3:0] ebe;
    logic [31:0] ewd, erd;
    longint v;
    size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    bad = f3 == 3'd3 || f3 >= 3'd6 || (wr && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || (int'(a[1:0]) % size != 0);
`endif
    off = int'(a[1:0]) - int'(a[1:0]) % size;
    ebe = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
    flt = bad || dly >= TO;
    erd = (flt || wr) ? 32'h0 : v[31:0];
    check({tag, " ready"}, 32'(bus.ready), 32'd1);
    bus.valid = 1'b1;
    bus.write = wr;
    bus.funct3 = f3;
    bus.addr = a;
    bus.wdata = wd;
    bus.mem_ack = 1'($urandom);
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    noise();
    bus.mem_ack = 1'b0;
    if (!bad) begin
      for (int k = 0; k < TO; k++) begin
        check({tag, " req/we/be"}, 32'({bus.mem_req, bus.mem_we, bus.mem_be}), 32'({1'b1, wr, ebe}));
        check({tag, " mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        if (wr) check({tag, " mem_wdata"}, bus.mem_wdata, ewd);
        check({tag, " ready/done in req"}, 32'({bus.ready, bus.done}), 32'd0);
        bus.mem_ack = (k == dly);
        bus.mem_rdata = (k == dly) ? rd : $urandom;
        @(posedge clk); #1;
        noise();
        bus.mem_ack = 1'b0;
        if (k == dly) break;
      end
    end
    check({tag, " done/fault"}, 32'({bus.done, bus.fault}), 32'({1'b1, flt}));
    check({tag, " rdata"}, bus.rdata, erd);
    check({tag, " mem idle"}, 32'({bus.mem_req, bus.mem_we, bus.mem_be}) | bus.mem_addr | bus.mem_wdata, 32'd0);
    check({tag, " ready in done"}, 32'(bus.ready), 32'd0);
    bus.mem_ack = 1'($urandom);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    bus.mem_ack = 1'b0;
    check({tag, " back idle"}, 32'({bus.ready, bus.done, bus.fault}), 32'b100);
    check({tag, " rdata cleared"}, bus.rdata, 32'd0);
  endtask
  initial begin
    bus.valid = 1'b0;
    bus.write = 1'b0;
    bus.funct3 = 3'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready/req/done/fault", 32'({bus.ready, bus.mem_req, bus.done, bus.fault}), 32'b1000);
    check("reset data", bus.mem_addr | bus.mem_wdata | bus.rdata | 32'(bus.mem_be) | 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    access("lw", 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    access("lb", 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8011_2233, 0);
    access("lbu", 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h8011_2233, 2);
    access("sh", 1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h1234_5678, 1);
    access("lh", 1'b0, 3'b001, 32'h0000_3002, 32'h0, 32'h8F00_0011, 1);
    access("lhu", 1'b0, 3'b101, 32'h0000_3000, 32'h0, 32'h0011_9ABC, 0);
    access("sb", 1'b1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 32'h0, 0);
    access("sw", 1'b1, 3'b010, 32'h0000_3008, 32'hCAFE_F00D, 32'h0, 2);
    access("timeout", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_1111, 99);
    access("ack at limit", 1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h2222_2222, TO - 1);
    access("lw misaligned", 1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'h3333_4444, 0);
    access("lh misaligned", 1'b0, 3'b001, 32'h0000_1003, 32'h0, 32'h8765_4321, 0);
    access("illegal 011", 1'b0, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 0);
    access("illegal 111", 1'b0, 3'b111, 32'h0000_6000, 32'h0, 32'h0, 0);
    access("store 100", 1'b1, 3'b100, 32'h0000_6000, 32'h55, 32'h0, 0);
    bus.valid = 1'b1;
    bus.write = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr = 32'h0000_4000;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    check("rst req cycle1", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    check("rst req cycle2", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst req dropped", 32'({bus.mem_req, bus.done}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst no done", 32'({bus.ready, bus.mem_req, bus.done}), 32'b100);
    end
    for (int i = 0; i < 300; i++)
      access("random", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
